multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_if.sv | 34 +++
 rtl/multicycle_controller.sv | 165 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath / unified memory.
// The controller side uses modport master; the datapath side uses modport slave.
interface multicycle_controller_if;
  logic [6:0] OP_Code;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       Illegal;
  logic       InstrDone;
  logic [3:0] State;

  modport master (
    input  OP_Code, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
    output Illegal, InstrDone, State
  );

  modport slave (
    output OP_Code, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
    input  Illegal, InstrDone, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM (lw, sw, R, I, jal, beq) with memory-ready stalls
// and a sticky trap state for unsupported opcodes.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic       illegal_q;
  logic       pc_update, branch;
  logic       adr_src, mem_write, ir_write, reg_write, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == StTrap);
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      StFetch: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.MemReady;
        pc_update  = bus.MemReady;
        if (bus.MemReady) state_d = StDecode;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.OP_Code)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpJal:           state_d = StJal;
          OpBeq:           state_d = StBeq;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.OP_Code == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (bus.MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        // MemWrite stays high across the whole wait; the store retires on the ready cycle.
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = bus.MemReady;
        if (bus.MemReady) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StBeq: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // Immediate format follows the opcode in every state, not just DECODE.
  always_comb begin
    imm_src = 2'b00;
    case (bus.OP_Code)
      OpStore: imm_src = 2'b01;
      OpBeq:   imm_src = 2'b10;
      OpJal:   imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign bus.PCWrite   = pc_update | (branch & bus.Zero);
  assign bus.AdrSrc    = adr_src;
  assign bus.MemWrite  = mem_write;
  assign bus.IRWrite   = ir_write;
  assign bus.RegWrite  = reg_write;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.ImmSrc    = imm_src;
  assign bus.Illegal   = illegal_q;
  assign bus.InstrDone = instr_done;
  assign bus.State     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: expected per-cycle state paths are built per instruction
// class from stall counts, and outputs are checked against a per-state output table.
module tb_multicycle_controller;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpBad   = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;
  step_t q[$];
  logic  zero_forced = 1'b0;
  logic  zero_val = 1'b0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] observed();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.Illegal, bus.InstrDone,
            bus.State};
  endfunction

  // Output table per state, taken from the control-signal description of each state.
  function automatic logic [20:0] expect_out(logic [3:0] st, logic mr, logic z, logic [6:0] opc);
    logic pcw, adr, mw, irw, rw, ill, done;
    logic [1:0] rs, sa, sb, op, imm;
    {pcw, adr, mw, irw, rw, ill, done} = '0;
    {rs, sa, sb, op} = '0;
    case (st)
      4'd0:  begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      4'd1:  begin sa = 2'b01; sb = 2'b01; end
      4'd2:  begin sa = 2'b10; sb = 2'b01; end
      4'd3:  adr = 1'b1;
      4'd4:  begin rs = 2'b01; rw = 1'b1; done = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; done = mr; end
      4'd6:  begin sa = 2'b10; op = 2'b10; end
      4'd7:  begin rw = 1'b1; done = 1'b1; end
      4'd8:  begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
      4'd9:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      4'd10: begin sa = 2'b10; op = 2'b01; pcw = z; done = 1'b1; end
      4'd11: ill = 1'b1;
      default: ;
    endcase
    if (opc == OpStore)    imm = 2'b01;
    else if (opc == OpBeq) imm = 2'b10;
    else if (opc == OpJal) imm = 2'b11;
    else                   imm = 2'b00;
    return {pcw, adr, mw, irw, rw, rs, sa, sb, op, imm, ill, done, st};
  endfunction

  task automatic check(string tag, logic [20:0] obs, logic [20:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(logic [3:0] st, logic mr);
    step_t s;
    s.st = st;
    s.mr = mr;
    q.push_back(s);
  endtask

  // Expected state path of one instruction: fs fetch stalls, ms data-memory stalls.
  task automatic push_instr(logic [6:0] opc, int fs, int ms);
    for (int i = 0; i < fs; i++) push(4'd0, 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, rnd());
    case (opc)
      OpLoad: begin
        push(4'd2, rnd());
        for (int i = 0; i < ms; i++) push(4'd3, 1'b0);
        push(4'd3, 1'b1);
        push(4'd4, rnd());
      end
      OpStore: begin
        push(4'd2, rnd());
        for (int i = 0; i < ms; i++) push(4'd5, 1'b0);
        push(4'd5, 1'b1);
      end
      OpR:   begin push(4'd6, rnd()); push(4'd7, rnd()); end
      OpI:   begin push(4'd8, rnd()); push(4'd7, rnd()); end
      OpJal: begin push(4'd9, rnd()); push(4'd7, rnd()); end
      OpBeq: push(4'd10, rnd());
      default: for (int i = 0; i < 3; i++) push(4'd11, rnd());
    endcase
  endtask

  // Called just after a rising edge; each step is checked mid-cycle.
  task automatic play(string tag, logic [6:0] opc);
    step_t s;
    bus.OP_Code = opc;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.MemReady = s.mr;
      bus.Zero = zero_forced ? zero_val : rnd();
      #1;
      check(tag, observed(), expect_out(s.st, s.mr, bus.Zero, opc));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(string tag, int edges);
    rst_n = 1'b0;
    for (int i = 0; i < edges; i++) begin
      bus.MemReady = rnd();
      @(posedge clk);
      #1;
      check(tag, observed(), expect_out(4'd0, bus.MemReady, bus.Zero, bus.OP_Code));
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] opc;
    logic [6:0] ops [7];
    ops = '{OpLoad, OpStore, OpR, OpI, OpJal, OpBeq, OpBad};
    rst_n = 1'b0;
    bus.OP_Code = OpR;
    bus.Zero = 1'b0;
    bus.MemReady = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset", 2);

    // R-type, no stalls: 0,1,6,7
    push_instr(OpR, 0, 0);
    play("rtype", OpR);

    // lw with MEMREAD held four cycles
    push_instr(OpLoad, 1, 3);
    play("lw_stall", OpLoad);

    zero_forced = 1'b1;
    zero_val = 1'b1;
    push_instr(OpBeq, 0, 0);
    play("beq_taken", OpBeq);
    zero_val = 1'b0;
    push_instr(OpBeq, 0, 0);
    play("beq_not_taken", OpBeq);
    zero_forced = 1'b0;

    push_instr(OpJal, 0, 0);
    play("jal", OpJal);

    push_instr(OpI, 2, 0);
    push_instr(OpI, 0, 0);
    play("itype", OpI);

    // Unsupported opcode: trap must hold with Illegal for well over ten cycles
    push(4'd0, 1'b1);
    push(4'd1, rnd());
    for (int i = 0; i < 12; i++) push(4'd11, rnd());
    play("trap_hold", OpBad);
    do_reset("trap_reset", 1);
    push_instr(OpR, 0, 0);
    play("after_trap", OpR);

    // Reset in the middle of a stalled store
    push(4'd0, 1'b1);
    push(4'd1, 1'b0);
    push(4'd2, 1'b0);
    push(4'd5, 1'b0);
    play("sw_pre_reset", OpStore);
    bus.MemReady = 1'b0;
    #1;
    check("sw_wait", observed(), expect_out(4'd5, 1'b0, bus.Zero, OpStore));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.MemReady = 1'b0;
    #1;
    check("sw_reset", observed(), expect_out(4'd0, 1'b0, bus.Zero, OpStore));
    @(posedge clk);
    #1;
    push(4'd0, 1'b1);
    push(4'd1, rnd());
    push(4'd2, rnd());
    push(4'd5, 1'b1);
    play("sw_after_reset", OpStore);

    // Random instruction stream with random stalls
    for (int n = 0; n < 60; n++) begin
      opc = ops[$urandom_range(0, 6)];
      push_instr(opc, $urandom_range(0, 2), $urandom_range(0, 3));
      play("random", opc);
      if (opc == OpBad) do_reset("random_reset", $urandom_range(1, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
